// File: rtl/fp_cmp_scheduler.sv
// Shares one FloPoCo subtractor, used as an a <= b comparator, among NREQ requesters.
// Round-robin by default; define CMP_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module fp_cmp_scheduler #(
  parameter int WIDTH   = 28,
  parameter int NREQ    = 3,
  parameter int SUB_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0] req_a,
  input  logic [NREQ*(WIDTH+1)-1:0] req_b,
  output logic [NREQ-1:0]           rsp_valid,
  output logic                      rsp_le,
  output logic                      rsp_nan,
  output logic                      busy
);
  localparam int OPW   = WIDTH + 1;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // decoded {le, nan} from the {exception, sign} fields of the difference
  function automatic logic [1:0] decode_le_nan(input logic [2:0] diff);
    case (diff[2:1])
      2'b00:   return 2'b10;
      2'b11:   return 2'b01;
      default: return {diff[0], 1'b0};
    endcase
  endfunction

  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] start_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             found;
  logic [WIDTH:0]   sel_a;
  logic [WIDTH:0]   sel_b;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = start_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
        found           = 1'b1;
      end
      scan_idx = (scan_idx == PTR_W'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

`ifdef CMP_SCHED_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (found)
      rr_ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign start_idx = rr_ptr;
`endif

  assign req_ready = grant;
  assign sel_a     = req_a[grant_idx*OPW +: OPW];
  assign sel_b     = req_b[grant_idx*OPW +: OPW];

  // ---- p0: operand register feeding the subtractor X/Y inputs
  logic            vld_p0;
  logic [NREQ-1:0] tag_p0;
  logic [WIDTH:0]  op_a_p0;
  logic [WIDTH:0]  op_b_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= found;
  end

  always_ff @(posedge clk) begin
    tag_p0  <= grant;
    op_a_p0 <= sel_a;
    op_b_p0 <= sel_b;
  end

  // ---- p1: subtractor pipeline; only the exception and sign of X-Y are carried
  logic [1:0]       xe, ye;
  logic             xs, ys;
  logic [WIDTH-3:0] xm, ym;
  logic [2:0]       sub_res;
  logic [2:0]       sub_p1 [SUB_LAT];

  assign xe = op_a_p0[WIDTH -: 2];
  assign ye = op_b_p0[WIDTH -: 2];
  assign xs = op_a_p0[WIDTH-2];
  assign ys = op_b_p0[WIDTH-2];
  assign xm = op_a_p0[WIDTH-3:0];
  assign ym = op_b_p0[WIDTH-3:0];

  always_comb begin
    sub_res = 3'b000;
    if (xe == 2'b11 || ye == 2'b11)
      sub_res = 3'b110;
    else if (xe == 2'b10 && ye == 2'b10)
      sub_res = (xs == ys) ? 3'b110 : {2'b10, xs};
    else if (xe == 2'b10)
      sub_res = {2'b10, xs};
    else if (ye == 2'b10)
      sub_res = {2'b10, ~ys};
    else if (xe == 2'b00 && ye == 2'b00)
      sub_res = 3'b000;
    else if (xe == 2'b00)
      sub_res = {2'b01, ~ys};
    else if (ye == 2'b00 || xs != ys)
      sub_res = {2'b01, xs};
    else if (xm == ym)
      sub_res = 3'b000;
    else
      sub_res = {2'b01, (xm > ym) ? xs : ~xs};
  end

  always_ff @(posedge clk) begin
    sub_p1[0] <= sub_res;
    for (int s = 1; s < SUB_LAT; s++)
      sub_p1[s] <= sub_p1[s-1];
  end

  // tag/valid shift register runs alongside the subtractor, one extra stage for diff_p2
  logic [SUB_LAT:0] vld_p1;
  logic [NREQ-1:0]  tag_p1 [SUB_LAT+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= '0;
    else     vld_p1 <= {vld_p1[SUB_LAT-1:0], vld_p0};
  end

  always_ff @(posedge clk) begin
    tag_p1[0] <= tag_p0;
    for (int s = 1; s <= SUB_LAT; s++)
      tag_p1[s] <= tag_p1[s-1];
  end

  // ---- p2: registered subtractor result, aligned with vld_p1[SUB_LAT]
  logic [2:0] diff_p2;
  logic [1:0] dec_p2;

  always_ff @(posedge clk) diff_p2 <= sub_p1[SUB_LAT-1];

  assign dec_p2 = decode_le_nan(diff_p2);

  // ---- p3: decision register driving the response ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_le    <= 1'b0;
      rsp_nan   <= 1'b0;
    end else begin
      rsp_valid <= vld_p1[SUB_LAT] ? tag_p1[SUB_LAT] : '0;
      rsp_le    <= vld_p1[SUB_LAT] & dec_p2[1];
      rsp_nan   <= vld_p1[SUB_LAT] & dec_p2[0];
    end
  end

  assign busy = vld_p0 | (|vld_p1) | (|rsp_valid);

endmodule
